// File: rtl/ground_scroll_pattern_pkg.sv
// Shared game constants: video timing, ground palette and scroll state encoding.
package ground_scroll_pattern_pkg;

    localparam int unsigned GAME_H_TOT      = 800;
    localparam int unsigned GAME_V_TOT      = 525;
    localparam int unsigned GAME_H_ACT      = 640;
    localparam int unsigned GAME_V_ACT      = 480;
    localparam int unsigned GAME_GROUND_POS = 435;
    localparam int unsigned GAME_COLOR_SIZE = 12;

    localparam logic [11:0] GRASS_A = 12'h0A2;
    localparam logic [11:0] GRASS_B = 12'h0C3;
    localparam logic [11:0] EDGE    = 12'h8A4;
    localparam logic [11:0] DIRT    = 12'h630;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SCROLL = 2'd1,
        ST_DECEL  = 2'd2
    } scroll_state_t;

endpackage

// File: rtl/frame_tick_gen.sv
// Frame tick decode: one-cycle pulse at the first pixel of the first blanking line.
// Ports: count_h/count_v - raster counters; tick_c - combinational tick.
module frame_tick_gen #(
    parameter int unsigned H_W   = 10,
    parameter int unsigned V_W   = 10,
    parameter int unsigned V_ACT = 480
) (
    input  logic [H_W-1:0] count_h,
    input  logic [V_W-1:0] count_v,
    output logic           tick_c
);

    assign tick_c = (count_h == '0) && (count_v == V_W'(V_ACT));

endmodule

// File: rtl/ground_scroll_pattern.sv
// Scrolling ground renderer: striped grass band, edge row and dirt, scrolled by a
// per-frame offset driven by an IDLE/SCROLL/DECEL speed controller.
// Ports: iClk/iRst - clock, sync active-high reset; iCountH/iCountV - raster position;
//        iRun/iSpeed - scroll request and speed; oDraw/oColor - registered pixel;
//        oOffset/oSpeed - current scroll offset and speed.
module ground_scroll_pattern
    import ground_scroll_pattern_pkg::*;
#(
    parameter int unsigned H_TOT      = GAME_H_TOT,
    parameter int unsigned V_TOT      = GAME_V_TOT,
    parameter int unsigned H_ACT      = GAME_H_ACT,
    parameter int unsigned V_ACT      = GAME_V_ACT,
    parameter int unsigned GROUND_POS = GAME_GROUND_POS,
    parameter int unsigned GRASS_H    = 6,
    parameter int unsigned STRIPE_W   = 16,
    parameter int unsigned SPEED_W    = 3,
    parameter int unsigned COLOR_SIZE = GAME_COLOR_SIZE
) (
    input  logic                            iClk,
    input  logic                            iRst,
    input  logic [$clog2(H_TOT)-1:0]        iCountH,
    input  logic [$clog2(V_TOT)-1:0]        iCountV,
    input  logic                            iRun,
    input  logic [SPEED_W-1:0]              iSpeed,
    output logic                            oDraw,
    output logic [COLOR_SIZE-1:0]           oColor,
    output logic [$clog2(2*STRIPE_W)-1:0]   oOffset,
    output logic [SPEED_W-1:0]              oSpeed
);

    localparam int unsigned H_W        = $clog2(H_TOT);
    localparam int unsigned V_W        = $clog2(V_TOT);
    localparam int unsigned OFF_W      = $clog2(2*STRIPE_W);
    localparam int unsigned STRIPE_BIT = $clog2(STRIPE_W);

    localparam logic [COLOR_SIZE-1:0] C_GRASS_A = COLOR_SIZE'(GRASS_A);
    localparam logic [COLOR_SIZE-1:0] C_GRASS_B = COLOR_SIZE'(GRASS_B);
    localparam logic [COLOR_SIZE-1:0] C_EDGE    = COLOR_SIZE'(EDGE);
    localparam logic [COLOR_SIZE-1:0] C_DIRT    = COLOR_SIZE'(DIRT);

    scroll_state_t           state, state_next;
    logic [SPEED_W-1:0]      speed, speed_next;
    logic [OFF_W-1:0]        offset, offset_next;
    logic                    draw, draw_next;
    logic [COLOR_SIZE-1:0]   color, color_next;
    logic                    tick_c;
    logic                    stripe_odd_c;

    frame_tick_gen #(
        .H_W   (H_W),
        .V_W   (V_W),
        .V_ACT (V_ACT)
    ) u_frame_tick_gen (
        .count_h (iCountH),
        .count_v (iCountV),
        .tick_c  (tick_c)
    );

    // Stripe phase: the selected bit of (x + offset), scrolling the pattern left.
    assign stripe_odd_c = 1'((iCountH + H_W'(offset)) >> STRIPE_BIT);

    // State, speed, offset and pixel registers; reset wins over a coincident tick.
    always_ff @(posedge iClk) begin
        if (iRst) begin
            state  <= ST_IDLE;
            speed  <= '0;
            offset <= '0;
            draw   <= 1'b0;
            color  <= '0;
        end else begin
            state  <= state_next;
            speed  <= speed_next;
            offset <= offset_next;
            draw   <= draw_next;
            color  <= color_next;
        end
    end

    // Next state/speed/offset on frame ticks, and next ground pixel every cycle.
    always_comb begin
        state_next  = state;
        speed_next  = speed;
        offset_next = offset;
        draw_next   = 1'b0;
        color_next  = '0;

        if (tick_c) begin
            // Offset advances by the speed in effect during the frame just ended.
            offset_next = offset + OFF_W'(speed);
            case (state)
                ST_IDLE: begin
                    if (iRun) begin
                        state_next = ST_SCROLL;
                        speed_next = iSpeed;
                    end
                end
                ST_SCROLL: begin
                    if (iRun) begin
                        speed_next = iSpeed;
                    end else begin
                        // Deceleration starts on the tick that sees the request drop.
                        state_next = ST_DECEL;
                        speed_next = (speed == '0) ? '0 : speed - SPEED_W'(1);
                    end
                end
                ST_DECEL: begin
                    if (iRun) begin
                        state_next = ST_SCROLL;
                        speed_next = iSpeed;
                    end else if (speed == '0) begin
                        state_next = ST_IDLE;
                    end else begin
                        speed_next = speed - SPEED_W'(1);
                    end
                end
                default: begin
                    state_next = ST_IDLE;
                    speed_next = '0;
                end
            endcase
        end

        if ((iCountH < H_W'(H_ACT)) && (iCountV >= V_W'(GROUND_POS)) &&
            (iCountV < V_W'(V_ACT))) begin
            draw_next = 1'b1;
            if (iCountV < V_W'(GROUND_POS + GRASS_H)) begin
                color_next = stripe_odd_c ? C_GRASS_B : C_GRASS_A;
            end else if (iCountV == V_W'(GROUND_POS + GRASS_H)) begin
                color_next = C_EDGE;
            end else begin
                color_next = C_DIRT;
            end
        end
    end

    assign oDraw   = draw;
    assign oColor  = color;
    assign oOffset = offset;
    assign oSpeed  = speed;

endmodule

// File: tb/tb_ground_scroll_pattern.sv
// Bench for ground_scroll_pattern: behavioural model checked every cycle, plus
// directed scenarios with hand-computed expectations and a randomized phase.
module tb_ground_scroll_pattern;
    import ground_scroll_pattern_pkg::*;

    localparam int M_IDLE   = 0;
    localparam int M_SCROLL = 1;
    localparam int M_DECEL  = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [9:0]  count_h;
    logic [9:0]  count_v;
    logic        run;
    logic [2:0]  spd_in;
    logic        draw;
    logic [11:0] color;
    logic [4:0]  offset;
    logic [2:0]  speed;

    int total = 0;
    int bad   = 0;

    int m_mode = M_IDLE;
    int m_spd  = 0;
    int m_off  = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    ground_scroll_pattern dut (
        .iClk    (clk),
        .iRst    (rst),
        .iCountH (count_h),
        .iCountV (count_v),
        .iRun    (run),
        .iSpeed  (spd_in),
        .oDraw   (draw),
        .oColor  (color),
        .oOffset (offset),
        .oSpeed  (speed)
    );

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int pix_draw(input int h, input int v);
        return (h < 640 && v >= 435 && v < 480) ? 1 : 0;
    endfunction

    function automatic int pix_color(input int h, input int v, input int off);
        if (pix_draw(h, v) == 0) return 0;
        if (v < 441) return (((h + off) / 16) % 2 == 0) ? int'(GRASS_A) : int'(GRASS_B);
        if (v == 441) return int'(EDGE);
        return 'h630;
    endfunction

    // Reference model: advances at each clock from the inputs seen at that edge.
    initial begin
        int h, v, si, e_draw, e_col;
        bit r, rn;
        forever begin
            @(posedge clk);
            h = int'(count_h); v = int'(count_v); si = int'(spd_in);
            r = rst; rn = run;
            if (r) begin
                m_mode = M_IDLE; m_spd = 0; m_off = 0;
                e_draw = 0; e_col = 0;
                chk_en = 1'b1;
            end else begin
                e_draw = pix_draw(h, v);
                e_col  = pix_color(h, v, m_off);
                if (h == 0 && v == 480) begin
                    m_off = (m_off + m_spd) % 32;
                    if (m_mode == M_IDLE) begin
                        if (rn) begin m_mode = M_SCROLL; m_spd = si; end
                    end else if (m_mode == M_SCROLL) begin
                        if (rn) m_spd = si;
                        else begin m_mode = M_DECEL; if (m_spd > 0) m_spd = m_spd - 1; end
                    end else begin
                        if (rn) begin m_mode = M_SCROLL; m_spd = si; end
                        else if (m_spd == 0) m_mode = M_IDLE;
                        else m_spd = m_spd - 1;
                    end
                end
            end
            #1;
            if (chk_en) begin
                check("model_draw",   int'(draw),   e_draw);
                check("model_color",  int'(color),  e_col);
                check("model_offset", int'(offset), m_off);
                check("model_speed",  int'(speed),  m_spd);
            end
        end
    end

    // Apply inputs (called at a falling edge) and return at the next falling edge.
    task automatic step(input int h, input int v, input bit r, input bit rn, input int s);
        count_h = 10'(h);
        count_v = 10'(v);
        rst     = r;
        run     = rn;
        spd_in  = 3'(s);
        @(negedge clk);
    endtask

    // Frame tick followed by one ordinary mid-frame cycle.
    task automatic tick(input bit rn, input int s);
        step(0, 480, 1'b0, rn, s);
        step(700, 500, 1'b0, rn, s);
    endtask

    initial begin
        int exp_off38 [8] = '{0, 5, 10, 15, 20, 25, 30, 3};
        int exp_spd39 [7] = '{6, 5, 4, 3, 2, 1, 0};
        int exp_off39 [7] = '{15, 21, 26, 30, 1, 3, 4};
        bit run_lvl;

        count_h = 10'd700; count_v = 10'd500; rst = 1'b1; run = 1'b0; spd_in = 3'd0;
        @(negedge clk);
        step(700, 500, 1'b1, 1'b0, 0);
        check("reset_offset", int'(offset), 0);
        check("reset_speed",  int'(speed),  0);
        check("reset_draw",   int'(draw),   0);
        check("reset_color",  int'(color),  0);

        // Two idle frames, then a grass pixel at offset 0.
        tick(1'b0, 0);
        tick(1'b0, 0);
        check("idle_offset", int'(offset), 0);
        check("idle_speed",  int'(speed),  0);
        step(100, 440, 1'b0, 1'b0, 0);
        check("grass_a_draw",  int'(draw),  1);
        check("grass_a_color", int'(color), int'(GRASS_A));

        // Constant speed 5: offset wraps at 32.
        for (int k = 0; k < 8; k++) begin
            tick(1'b1, 5);
            check("scroll5_offset", int'(offset), exp_off38[k]);
            check("scroll5_speed",  int'(speed),  5);
        end

        // Speed 7 then release: speed ramps down, offset freezes.
        tick(1'b1, 7);
        check("spd7_offset", int'(offset), 8);
        check("spd7_speed",  int'(speed),  7);
        for (int k = 0; k < 7; k++) begin
            tick(1'b0, 0);
            check("decel_speed",  int'(speed),  exp_spd39[k]);
            check("decel_offset", int'(offset), exp_off39[k]);
        end
        for (int k = 0; k < 2; k++) begin
            tick(1'b0, 0);
            check("stopped_offset", int'(offset), 4);
            check("stopped_speed",  int'(speed),  0);
        end

        // Re-request during deceleration at speed 3.
        tick(1'b1, 4);
        tick(1'b0, 0);
        check("decel3_speed", int'(speed), 3);
        tick(1'b1, 2);
        check("resume_speed",  int'(speed),  2);
        check("resume_offset", int'(offset), 11);
        step(300, 100, 1'b0, 1'b1, 6);
        check("midframe_speed_held", int'(speed), 2);
        tick(1'b0, 0);
        check("scroll_drop_speed",  int'(speed),  1);
        check("scroll_drop_offset", int'(offset), 13);
        tick(1'b0, 0);
        tick(1'b0, 0);
        check("back_idle_offset", int'(offset), 14);

        // Region boundaries and one-cycle latency.
        step(639, 479, 1'b0, 1'b0, 0);
        check("px639_479_draw",  int'(draw),  1);
        check("px639_479_color", int'(color), 'h630);
        step(640, 479, 1'b0, 1'b0, 0);
        check("px640_479_draw",  int'(draw),  0);
        check("px640_479_color", int'(color), 0);
        step(0, 434, 1'b0, 1'b0, 0);
        check("px0_434_draw", int'(draw), 0);
        step(0, 441, 1'b0, 1'b0, 0);
        check("edge_draw",  int'(draw),  1);
        check("edge_color", int'(color), int'(EDGE));
        count_h = 10'd0; count_v = 10'd434;
        #1;
        check("latency_hold_draw", int'(draw), 1);
        @(negedge clk);
        check("latency_after_draw", int'(draw), 0);
        step(0, 442, 1'b0, 1'b0, 0);
        check("dirt_draw",  int'(draw),  1);
        check("dirt_color", int'(color), 'h630);

        // Reset coinciding with a tick at speed 4.
        tick(1'b1, 4);
        tick(1'b1, 4);
        check("pre_rst_offset", int'(offset), 18);
        step(0, 480, 1'b1, 1'b1, 4);
        check("rst_tick_offset", int'(offset), 0);
        check("rst_tick_speed",  int'(speed),  0);
        check("rst_tick_draw",   int'(draw),   0);
        step(700, 500, 1'b0, 1'b0, 0);
        tick(1'b0, 0);
        check("post_rst_offset", int'(offset), 0);
        tick(1'b1, 3);
        check("post_rst_speed", int'(speed), 3);

        // Randomized raster positions, ticks, run level, speed and rare resets.
        run_lvl = 1'b1;
        for (int i = 0; i < 4000; i++) begin
            int h, v;
            h = int'($urandom_range(0, 799));
            v = int'($urandom_range(0, 524));
            if ($urandom_range(0, 9) == 0) begin h = 0; v = 480; end
            if ($urandom_range(0, 59) == 0) run_lvl = ~run_lvl;
            step(h, v, $urandom_range(0, 499) == 0, run_lvl, int'($urandom_range(0, 7)));
        end

        step(700, 500, 1'b0, 1'b0, 0);
        step(700, 500, 1'b0, 1'b0, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
